// File: rtl/spi_flash_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module : spi_flash_reader_pkg
// Brief  : Shared state encoding, command constants and helpers for the reader.
// Rev    : 1.0
// ============================================================================
package spi_flash_reader_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [7:0] CMD_READ       = 8'h03;
  localparam int         XFER_BITS      = 64;
  localparam int         DATA_START_BIT = 32;

  // Serial bytes arrive address-ascending; the bus word is little-endian.
  function automatic logic [31:0] byte_swap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_flash_reader_sck.sv
`default_nettype none
// ============================================================================
// Module : spi_flash_reader_sck
// Brief  : Mode-0 SPI clock generator: DIV-cycle half periods, rise/fall strobes.
// Rev    : 1.0
// ============================================================================
module spi_flash_reader_sck #(
  parameter int DIV = 1
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_en,
  output logic o_sck,
  output logic o_rise,
  output logic o_fall
);

  localparam logic [7:0] c_last = 8'(DIV - 1);

  logic [7:0] r_phase;
  logic       r_sck;
  logic       w_wrap;

  // Strobes flag the cycle whose closing edge toggles sck.
  assign w_wrap = i_en && (r_phase == c_last);
  assign o_rise = w_wrap && !r_sck;
  assign o_fall = w_wrap && r_sck;
  assign o_sck  = r_sck;

  always_ff @(posedge i_clock) begin
    if (i_reset || !i_en) begin
      r_phase <= 8'd0;
      r_sck   <= 1'b0;
    end else if (w_wrap) begin
      r_phase <= 8'd0;
      r_sck   <= ~r_sck;
    end else begin
      r_phase <= r_phase + 8'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/spi_flash_reader.sv
`default_nettype none
// ============================================================================
// Module : spi_flash_reader
// Brief  : Single-word 03h READ SPI master; optional one-entry word cache
//          enabled by defining SPI_FLASH_READER_CACHE_EN.
// Rev    : 1.0
// ============================================================================
module spi_flash_reader
  import spi_flash_reader_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [23:0] i_req_addr,
  output logic        o_resp_valid,
  input  logic        i_resp_ready,
  output logic [31:0] o_resp_data,
  output logic        o_sck,
  output logic        o_ss,
  output logic        o_mosi,
  input  logic        i_miso
);

  localparam logic [5:0] c_last_bit   = 6'(XFER_BITS - 1);
  localparam logic [5:0] c_data_start = 6'(DATA_START_BIT);

  state_t      r_state;
  logic [31:0] r_tx;
  logic [31:0] r_rx;
  logic [5:0]  r_bit;
  logic        r_ss;
  logic        r_req_ready;
  logic        r_resp_valid;
  logic [31:0] r_resp_data;

  logic        w_rise;
  logic        w_fall;
  logic        w_accept;
  logic        w_hit;
  logic [31:0] w_hit_data;

`ifdef SPI_FLASH_READER_CACHE_EN
  logic        r_c_valid;
  logic [21:0] r_c_addr;
  logic [31:0] r_c_data;
  logic [21:0] r_addr;

  assign w_hit      = r_c_valid && (r_c_addr == i_req_addr[23:2]);
  assign w_hit_data = r_c_data;
`else
  assign w_hit      = 1'b0;
  assign w_hit_data = 32'd0;
`endif

  assign w_accept     = i_req_valid && r_req_ready;
  assign o_req_ready  = r_req_ready;
  assign o_resp_valid = r_resp_valid;
  assign o_resp_data  = r_resp_data;
  assign o_ss         = r_ss;
  assign o_mosi       = r_tx[31];

  spi_flash_reader_sck #(.DIV(DIV)) u_sck (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_en    (r_state == XFER),
    .o_sck   (o_sck),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state      <= IDLE;
      r_tx         <= 32'd0;
      r_rx         <= 32'd0;
      r_bit        <= 6'd0;
      r_ss         <= 1'b1;
      r_req_ready  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_data  <= 32'd0;
`ifdef SPI_FLASH_READER_CACHE_EN
      r_c_valid    <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_req_ready <= 1'b1;
          if (w_accept) begin
            r_req_ready <= 1'b0;
            if (w_hit) begin
              r_state      <= RESP;
              r_resp_valid <= 1'b1;
              r_resp_data  <= w_hit_data;
            end else begin
              r_state <= XFER;
              r_tx    <= {CMD_READ, i_req_addr & 24'hFFFFFC};
              r_bit   <= 6'd0;
              r_ss    <= 1'b0;
`ifdef SPI_FLASH_READER_CACHE_EN
              r_addr  <= i_req_addr[23:2];
`endif
            end
          end
        end
        XFER: begin
          if (w_rise && (r_bit >= c_data_start)) begin
            r_rx <= {r_rx[30:0], i_miso};
          end
          // Shifting on the fall starts the next bit's low phase; zeros follow the address.
          if (w_fall) begin
            r_tx  <= {r_tx[30:0], 1'b0};
            r_bit <= r_bit + 6'd1;
            if (r_bit == c_last_bit) begin
              r_state      <= RESP;
              r_ss         <= 1'b1;
              r_resp_valid <= 1'b1;
              r_resp_data  <= byte_swap(r_rx);
`ifdef SPI_FLASH_READER_CACHE_EN
              r_c_valid    <= 1'b1;
              r_c_addr     <= r_addr;
              r_c_data     <= byte_swap(r_rx);
`endif
            end
          end
        end
        RESP: begin
          if (i_resp_ready) begin
            r_state      <= IDLE;
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
